load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n, sampled only on the clk rising edge.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 start  in  1  one-cycle request from control; valid only when opcode is LOAD or STORE.
REQ-005 opcode  in  7  instruction opcode (LOAD 0000011, STORE 0100011).
REQ-006 funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 addr  in  32  effective address from the ALU result bus (base + imm).
REQ-008 wdata  in  32  store data (rs2 value).
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 fault  out  1  valid with done; misaligned or illegal funct3.
REQ-012 rdata  out  32  extended load result; held until the next done.
REQ-013 mem_req  out  1  memory request, held until mem_ack.
REQ-014 mem_we  out  1  1 store, 0 load; valid with mem_req.
REQ-015 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-016 mem_be  out  4  byte enables, bit i = byte lane i.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_rdata  in  32  read data; valid with mem_ack on loads.
REQ-019 mem_ack  in  1  one-cycle memory acknowledge.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE, FAULT.
- IDLE: start -> FAULT if check fails, else ACCESS.
- ACCESS: stay until mem_ack; mem_ack -> DONE.
- DONE and FAULT: one cycle each, then IDLE.
REQ-021 In IDLE with start high, opcode, funct3, addr and wdata SHALL be latched; operands SHALL not be re-sampled until the next IDLE.
REQ-022 start SHALL be ignored outside IDLE, or when opcode is neither LOAD nor STORE.
REQ-023 The check SHALL fail when: H/HU and addr[0]=1; W and addr[1:0]!=0; LOAD funct3 in {011,110,111}; STORE funct3 >= 011.
REQ-024 mem_req SHALL be high exactly while in ACCESS; mem_ack is allowed in the first ACCESS cycle, giving a minimum latency of start to done = 2 cycles.
REQ-025 mem_ack outside ACCESS SHALL be ignored.
REQ-026 done SHALL be high in DONE and FAULT; fault SHALL be high only in FAULT, where rdata becomes 0 and no memory access occurs.
REQ-027 Store enables and data:
- SB: mem_be = 1<<addr[1:0]; mem_wdata = byte replicated x4.
- SH: mem_be = 0011 or 1100 by addr[1]; halfword replicated x2.
- SW: mem_be = 1111.
REQ-028 Load lanes: lane chosen by addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend; W passes through; rdata SHALL be captured on the mem_ack cycle.
REQ-029 mem_be SHALL be 1111 on loads.
REQ-030 Stores SHALL leave rdata unchanged.

Reset
REQ-031 With rst_n low at a clk edge: state = IDLE; busy, done, fault, mem_req, mem_we = 0; mem_be = 0; rdata, mem_addr, mem_wdata = 0.
REQ-032 Reset during ACCESS SHALL abort the access: mem_req drops on that edge and no done is issued.

Structure
REQ-033 Shared package riscv_pkg SHALL hold the OP_LOAD/OP_STORE constants, the funct3 size codes and the lsu_state_t enum.
REQ-034 Lane steering and extension SHALL live in the combinational sub-module lsu_align; the FSM and registers SHALL live in load_store_unit.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ack in first ACCESS cycle -> mem_addr 0x100, be 1111, done 2 cycles after start, rdata 0xDEADBEEF.
- LB addr 0x103, mem_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x22, wdata 0x1234ABCD -> mem_we 1, mem_addr 0x20, be 1100, mem_wdata 0xABCDABCD.
- LW addr 0x101 -> no mem_req; done and fault high for 1 cycle; rdata 0.
- SB with ack delayed 5 cycles and a second start during busy -> single access; done 1 cycle after ack; second start ignored.
- rst_n low in ACCESS cycle 2 -> mem_req 0 next cycle; no done; IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store constants, the LSU state type and the access legality check.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } lsu_state_t;

  // True when the access size code is legal for the direction and the address is naturally aligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b1;
    if ((f3 == F3_H || f3 == F3_HU) && addr_lo[0]) ok = 1'b0;
    if (f3 == F3_W && addr_lo != 2'b00) ok = 1'b0;
    if (is_store) begin
      if (f3 >= 3'b011) ok = 1'b0;
    end else begin
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane selection plus sign/zero extension for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Store enables and replicated data; loads always read the whole word.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load result extension by access size.
  always_comb begin
    rdata_ext = mem_rdata;
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'd0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'd0, half_sel};
      default: rdata_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: latches one request, runs a single memory handshake, reports done/fault.
//   state     | meaning
//   ST_IDLE   | waiting for an accepted start
//   ST_ACCESS | mem_req held until mem_ack
//   ST_DONE   | one-cycle completion pulse
//   ST_FAULT  | one-cycle completion with fault, no memory access
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  lsu_state_t  state_q, state_d;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic        accept;
  logic        check_ok;
  logic [3:0]  be_lane;
  logic [31:0] rdata_ext;

  assign store_q  = (opcode_q == OP_STORE);
  assign accept   = (state_q == ST_IDLE) && start && (opcode == OP_LOAD || opcode == OP_STORE);
  assign check_ok = access_ok(opcode == OP_STORE, funct3, addr[1:0]);
  assign mem_addr = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .is_store   (store_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .mem_rdata  (mem_rdata),
    .be         (be_lane),
    .wdata_lane (mem_wdata),
    .rdata_ext  (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    fault   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_be  = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = check_ok ? ST_ACCESS : ST_FAULT;
      end
      ST_ACCESS: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = store_q;
        mem_be  = be_lane;
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        busy    = 1'b1;
        done    = 1'b1;
        fault   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, only on an accepted start so operands stay frozen during the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_q <= '0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      opcode_q <= opcode;
      funct3_q <= funct3;
      addr_q   <= addr;
      wdata_q  <= wdata;
    end
  end

  // Load result: cleared on a faulting request, captured on the load's ack, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (accept && !check_ok) begin
      rdata <= '0;
    end else if (state_q == ST_ACCESS && mem_ack && !store_q) begin
      rdata <= rdata_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a size/offset arithmetic model.
module tb_load_store_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic exp_fault(input logic is_st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (is_st) legal = (f3 <= 3'd2);
    else       legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return !legal || ((a % size_of(f3)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic is_st, input logic [2:0] f3, input logic [31:0] a);
    if (!is_st || f3 == 3'd2) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    return 4'(3 << ((a % 4) / 2 * 2));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd % 256) * 32'h0101_0101;
    if (f3 == 3'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (size_of(f3) == 1) begin
      v = (rd >> ((a % 4) * 8)) % 256;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size_of(f3) == 2) begin
      v = (rd >> (((a % 4) / 2) * 16)) % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One request: start, optional ack delay, optional extra start while busy.
  task automatic xact(input logic is_st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int dly, input bit poke);
    @(negedge clk);
    opcode = is_st ? ST : LD; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); opcode = LD;
    if (exp_fault(is_st, f3, a)) begin
      ref_rdata = 32'd0;
      chk("fault_done", 32'(done), 32'd1);
      chk("fault_flag", 32'(fault), 32'd1);
      chk("fault_noreq", 32'(mem_req), 32'd0);
      chk("fault_be", 32'(mem_be), 32'd0);
      chk("fault_rdata", rdata, 32'd0);
      @(negedge clk);
      chk("fault_done_end", 32'(done), 32'd0);
      chk("fault_busy_end", 32'(busy), 32'd0);
      return;
    end
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_req", 32'(mem_req), 32'd1);
    chk("acc_done", 32'(done), 32'd0);
    chk("acc_we", 32'(mem_we), 32'(is_st));
    chk("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("acc_be", 32'(mem_be), 32'(exp_be(is_st, f3, a)));
    if (is_st) chk("acc_wdata", mem_wdata, exp_wdata(f3, wd));
    for (int k = 0; k < dly; k++) begin
      if (poke && k == 0) begin
        start = 1'b1; opcode = LD; funct3 = 3'd2; addr = 32'h0000_0400;
      end
      @(negedge clk);
      start = 1'b0;
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("wait_done", 32'(done), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (!is_st) ref_rdata = exp_load(f3, a, rd);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_fault", 32'(fault), 32'd0);
    chk("done_noreq", 32'(mem_req), 32'd0);
    chk("done_rdata", rdata, ref_rdata);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_rdata", rdata, ref_rdata);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic        rst;
    rst_n = 1'b0; start = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0;
    wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed scenarios
    xact(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    xact(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 1'b0);
    xact(1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 1'b0);
    xact(1'b1, 3'd1, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 0, 1'b0);
    chk("store_keeps_rdata", rdata, 32'h0000_0080);
    xact(1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 0, 1'b0);
    xact(1'b1, 3'd0, 32'h0000_0042, 32'hCAFE_0057, 32'd0, 5, 1'b1);

    // Start with a non-memory opcode, and a stray ack in IDLE, must both be ignored.
    @(negedge clk);
    start = 1'b1; opcode = 7'b0110011; funct3 = 3'd2; addr = 32'h10;
    mem_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    chk("bad_op_busy", 32'(busy), 32'd0);
    chk("bad_op_req", 32'(mem_req), 32'd0);
    chk("stray_ack_done", 32'(done), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'(size_of(rf3) - 1);
      rst = 1'($urandom);
      xact(rst, rf3, ra, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset in the second ACCESS cycle aborts the load.
    @(negedge clk);
    opcode = LD; funct3 = 3'd2; addr = 32'h0000_0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_req_c1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("abort_req_c2", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 32'd0;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("abort_late_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    xact(1'b0, 3'd5, 32'h0000_0302, 32'd0, 32'h8001_7FFF, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
